// File: rtl/pixel_dispatcher_if.sv
// Coordinate offer channel between the pixel dispatcher and its ray-tracing cores.
interface pixel_dispatcher_if #(
  parameter int unsigned MAX_CORES = 2,
  parameter int unsigned COORD_W   = 13
);
  logic [MAX_CORES-1:0] core_valid;
  logic [MAX_CORES-1:0] core_ready;
  logic [COORD_W-1:0]   x_out;
  logic [COORD_W-1:0]   y_out;

  modport master (output core_valid, x_out, y_out, input core_ready);
  modport slave  (input core_valid, x_out, y_out, output core_ready);
endinterface

// File: rtl/pixel_dispatcher.sv
// Walks a frame in raster order and offers each pixel coordinate to the active
// cores in strict round-robin, one transfer per valid/ready handshake.
module pixel_dispatcher #(
  parameter int unsigned MAX_CORES = 2,
  parameter int unsigned COORD_W   = 13
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COORD_W-1:0]     image_width,
  input  logic [COORD_W-1:0]     image_height,
  input  logic [2:0]             no_of_extra_cores,
  pixel_dispatcher_if.master     core_if,
  output logic                   busy,
  output logic                   frame_done,
  output logic [2*COORD_W-1:0]   pixels_sent
);

  typedef enum logic [1:0] {IDLE, DISPATCH, DONE} state_t;

  localparam logic [2:0] MAX_LAST = 3'(MAX_CORES - 1);

  state_t               state, next_state;
  logic [COORD_W-1:0]   width, height;
  logic [COORD_W-1:0]   x, y;
  logic [2:0]           cur_core, last_core;
  logic                 xfer;
  logic                 last_col, last_pix;

  // Valid depends only on registered state, so ready never reaches it.
  always_comb begin
    core_if.core_valid = '0;
    for (int unsigned i = 0; i < MAX_CORES; i++) begin
      core_if.core_valid[i] = (state == DISPATCH) && (cur_core == 3'(i));
    end
  end

  assign core_if.x_out = x;
  assign core_if.y_out = y;
  assign busy          = (state == DISPATCH);
  assign frame_done    = (state == DONE);

  assign xfer     = |(core_if.core_valid & core_if.core_ready);
  assign last_col = (x == width - COORD_W'(1));
  assign last_pix = last_col && (y == height - COORD_W'(1));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if ((image_width == '0) || (image_height == '0)) next_state = DONE;
          else                                             next_state = DISPATCH;
        end
      end
      DISPATCH: begin
        if (abort)                 next_state = IDLE;
        else if (xfer && last_pix) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      width       <= '0;
      height      <= '0;
      last_core   <= '0;
      x           <= '0;
      y           <= '0;
      cur_core    <= '0;
      pixels_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            width       <= image_width;
            height      <= image_height;
            last_core   <= (no_of_extra_cores > MAX_LAST) ? MAX_LAST : no_of_extra_cores;
            x           <= '0;
            y           <= '0;
            cur_core    <= '0;
            pixels_sent <= '0;
          end
        end
        DISPATCH: begin
          // A transfer coinciding with abort still advances the count.
          if (xfer) begin
            pixels_sent <= pixels_sent + (2*COORD_W)'(1);
            if (last_col) begin
              x <= '0;
              y <= y + COORD_W'(1);
            end else begin
              x <= x + COORD_W'(1);
            end
            cur_core <= (cur_core == last_core) ? 3'd0 : cur_core + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Table-driven bench for pixel_dispatcher plus hand sequences for async reset.
module tb_pixel_dispatcher;

  localparam int unsigned MC = 2;
  localparam int unsigned CW = 13;

  logic            aclk = 1'b0;
  logic            areset;
  logic            start, abort;
  logic [CW-1:0]   image_width, image_height;
  logic [2:0]      no_of_extra_cores;
  logic            busy, frame_done;
  logic [2*CW-1:0] pixels_sent;

  pixel_dispatcher_if #(.MAX_CORES(MC), .COORD_W(CW)) cif ();

  pixel_dispatcher #(.MAX_CORES(MC), .COORD_W(CW)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .start             (start),
    .abort             (abort),
    .image_width       (image_width),
    .image_height      (image_height),
    .no_of_extra_cores (no_of_extra_cores),
    .core_if           (cif.master),
    .busy              (busy),
    .frame_done        (frame_done),
    .pixels_sent       (pixels_sent)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        st, ab;
    int          w, h, xc;
    logic [1:0]  rdy;
    logic [1:0]  ev;
    int          ex, ey;
    logic        eb, ed;
    int          ec;
  } vec_t;

  vec_t rows[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cur_row = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h expected %0h", nm, cur_row, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic ab, input int w, input int h, input int xc,
                     input logic [1:0] rdy, input logic [1:0] ev, input int ex, input int ey,
                     input logic eb, input logic ed, input int ec);
    vec_t v;
    v.st = st; v.ab = ab; v.w = w; v.h = h; v.xc = xc; v.rdy = rdy;
    v.ev = ev; v.ex = ex; v.ey = ey; v.eb = eb; v.ed = ed; v.ec = ec;
    rows.push_back(v);
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic run_rows();
    foreach (rows[i]) begin
      @(posedge aclk); #1;
      start             = rows[i].st;
      abort             = rows[i].ab;
      image_width       = CW'(rows[i].w);
      image_height      = CW'(rows[i].h);
      no_of_extra_cores = 3'(rows[i].xc);
      cif.core_ready    = rows[i].rdy;
      @(negedge aclk);
      chk("core_valid",  32'(cif.core_valid), 32'(rows[i].ev));
      chk("busy",        32'(busy),           32'(rows[i].eb));
      chk("frame_done",  32'(frame_done),     32'(rows[i].ed));
      chk("pixels_sent", 32'(pixels_sent),    32'(rows[i].ec));
      if (rows[i].ev != 2'b00) begin
        chk("x_out", 32'(cif.x_out), 32'(rows[i].ex));
        chk("y_out", 32'(cif.y_out), 32'(rows[i].ey));
      end
      cur_row++;
    end
    rows.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(cif.core_valid), 32'd0);
    chk({tag, "_x"},     32'(cif.x_out),      32'd0);
    chk({tag, "_y"},     32'(cif.y_out),      32'd0);
    chk({tag, "_busy"},  32'(busy),           32'd0);
    chk({tag, "_done"},  32'(frame_done),     32'd0);
    chk({tag, "_count"}, 32'(pixels_sent),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1; start = 1'b0; abort = 1'b0;
    image_width = '0; image_height = '0; no_of_extra_cores = '0;
    cif.core_ready = '0;
    #12;
    chk_reset_vals("reset");
    areset = 1'b0;

    // 4x2, two cores, ready high; config changes after the latch are ignored
    add(1,0, 4,2,1, 2'b11, 2'b00,0,0, 0,0,0);
    add(0,0, 7,7,0, 2'b11, 2'b01,0,0, 1,0,0);
    add(0,0, 7,7,0, 2'b11, 2'b10,1,0, 1,0,1);
    add(0,0, 7,7,0, 2'b11, 2'b01,2,0, 1,0,2);
    add(0,0, 7,7,0, 2'b11, 2'b10,3,0, 1,0,3);
    add(0,0, 7,7,0, 2'b11, 2'b01,0,1, 1,0,4);
    add(0,0, 7,7,0, 2'b11, 2'b10,1,1, 1,0,5);
    add(0,0, 7,7,0, 2'b11, 2'b01,2,1, 1,0,6);
    add(0,0, 7,7,0, 2'b11, 2'b10,3,1, 1,0,7);
    add(1,1, 4,2,1, 2'b11, 2'b00,0,0, 0,1,8);
    add(0,1, 4,2,1, 2'b11, 2'b00,0,0, 0,0,8);
    add(0,0, 4,2,1, 2'b11, 2'b00,0,0, 0,0,8);

    // 3x3, one core, selected ready toggles, unselected ready held high
    add(1,0, 3,3,0, 2'b00, 2'b00,0,0, 0,0,8);
    for (int k = 0; k < 18; k++) begin
      int p;
      p = k / 2;
      add((k == 4) ? 1'b1 : 1'b0, 0, 3,3,0, (k % 2 == 1) ? 2'b11 : 2'b10,
          2'b01, p % 3, p / 3, 1, 0, p);
    end
    add(0,0, 3,3,0, 2'b00, 2'b00,0,0, 0,1,9);
    add(0,0, 3,3,0, 2'b00, 2'b00,0,0, 0,0,9);

    // 3x1 with extra cores above the maximum: clamped to two cores
    add(1,0, 3,1,5, 2'b11, 2'b00,0,0, 0,0,9);
    add(0,0, 3,1,5, 2'b11, 2'b01,0,0, 1,0,0);
    add(0,0, 3,1,5, 2'b11, 2'b10,1,0, 1,0,1);
    add(0,0, 3,1,5, 2'b11, 2'b01,2,0, 1,0,2);
    add(0,0, 3,1,5, 2'b11, 2'b00,0,0, 0,1,3);
    add(0,0, 3,1,5, 2'b11, 2'b00,0,0, 0,0,3);

    // zero width: straight to DONE, never any valid
    add(1,0, 0,5,1, 2'b11, 2'b00,0,0, 0,0,3);
    add(0,0, 0,5,1, 2'b11, 2'b00,0,0, 0,1,0);
    add(0,0, 0,5,1, 2'b11, 2'b00,0,0, 0,0,0);

    // 4x4, start+abort together in IDLE, abort on the third transfer
    add(1,1, 4,4,1, 2'b11, 2'b00,0,0, 0,0,0);
    add(0,0, 4,4,1, 2'b11, 2'b01,0,0, 1,0,0);
    add(0,0, 4,4,1, 2'b11, 2'b10,1,0, 1,0,1);
    add(0,1, 4,4,1, 2'b11, 2'b01,2,0, 1,0,2);
    add(0,0, 4,4,1, 2'b11, 2'b00,0,0, 0,0,3);
    add(0,0, 4,4,1, 2'b11, 2'b00,0,0, 0,0,3);
    // restart at (0,0) on core 0, holding while ready is low, then abort
    add(1,0, 4,4,1, 2'b00, 2'b00,0,0, 0,0,3);
    add(0,0, 4,4,1, 2'b00, 2'b01,0,0, 1,0,0);
    add(0,0, 4,4,1, 2'b00, 2'b01,0,0, 1,0,0);
    add(0,1, 4,4,1, 2'b00, 2'b01,0,0, 1,0,0);
    add(0,0, 4,4,1, 2'b11, 2'b00,0,0, 0,0,0);

    // mid-frame: three transfers done by the edge before the reset pulse
    add(1,0, 4,4,1, 2'b11, 2'b00,0,0, 0,0,0);
    add(0,0, 4,4,1, 2'b11, 2'b01,0,0, 1,0,0);
    add(0,0, 4,4,1, 2'b11, 2'b10,1,0, 1,0,1);
    add(0,0, 4,4,1, 2'b11, 2'b01,2,0, 1,0,2);
    run_rows();

    @(posedge aclk); #2;
    areset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    #1;
    areset = 1'b0;

    add(1,0, 4,4,1, 2'b11, 2'b00,0,0, 0,0,0);
    add(0,0, 4,4,1, 2'b11, 2'b01,0,0, 1,0,0);
    add(0,0, 4,4,1, 2'b11, 2'b10,1,0, 1,0,1);
    run_rows();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
